// File: rtl/player_controller_gen2.sv
// rtl/player_controller_gen2.sv - Dino player FSM with lives, invulnerability, jump arc and optional pause
// Optional pause state is built when PLAYER_PAUSE_EN is defined.
module player_controller_gen2 #(
    parameter int POS_W        = 6,
    parameter int JUMP_HEIGHT  = 24,
    parameter int JUMP_STEP    = 4,
    parameter int LIVES        = 3,
    parameter int LIVES_W      = 2,
    parameter int INVULN_TICKS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         game_tick,
    input  logic               button_up,
    input  logic               button_down,
    input  logic               button_start,
    input  logic               crash,
    output logic [POS_W-1:0]   player_position,
    output logic [LIVES_W-1:0] lives_left,
    output logic [2:0]         game_state,
    output logic               invulnerable,
    output logic               game_start_pulse,
    output logic               jump_pulse,
    output logic               hit_pulse,
    output logic               game_over_pulse
);

    localparam int INV_W = $clog2(INVULN_TICKS + 1);
    localparam logic [POS_W:0]   STEP_X   = (POS_W+1)'(JUMP_STEP);
    localparam logic [POS_W:0]   HEIGHT_X = (POS_W+1)'(JUMP_HEIGHT);
    localparam logic [LIVES_W-1:0] LIVES_X = LIVES_W'(LIVES);
    localparam logic [INV_W-1:0] INV_X    = INV_W'(INVULN_TICKS);
    localparam logic PH_UP   = 1'b0;
    localparam logic PH_DOWN = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_JUMPING   = 3'd1,
        S_RUNNING1  = 3'd2,
        S_RUNNING2  = 3'd3,
        S_DUCKING   = 3'd4,
        S_GAME_OVER = 3'd5,
        S_PAUSED    = 3'd6,
        S_UNUSED    = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [INV_W-1:0]   inv_q, inv_d;
    logic               phase_q, phase_d;
    logic               start_prev_q;
`ifdef PLAYER_PAUSE_EN
    state_t             saved_q, saved_d;
`endif

    logic             frame, phys, start_edge, active, crash_ok, fatal, hit;
    logic [POS_W:0]   pos_ext, pos_up;

    assign frame      = game_tick[0];
    assign phys       = game_tick[1];
    assign start_edge = frame & button_start & ~start_prev_q;
    assign active     = (state_q == S_RUNNING1) || (state_q == S_RUNNING2) ||
                        (state_q == S_DUCKING)  || (state_q == S_JUMPING);
    assign crash_ok   = crash & active & ~invulnerable;
    assign fatal      = crash_ok && (lives_q == LIVES_W'(1));
    assign hit        = crash_ok && (lives_q > LIVES_W'(1));
    assign pos_ext    = {1'b0, pos_q};
    assign pos_up     = pos_ext + STEP_X;

    always_comb begin
        state_d          = state_q;
        pos_d            = pos_q;
        lives_d          = lives_q;
        inv_d            = inv_q;
        phase_d          = phase_q;
        game_start_pulse = 1'b0;
        jump_pulse       = 1'b0;
        hit_pulse        = 1'b0;
        game_over_pulse  = 1'b0;
`ifdef PLAYER_PAUSE_EN
        saved_d          = saved_q;
`endif

        if (frame && (inv_q != '0) && (state_q != S_PAUSED))
            inv_d = inv_q - INV_W'(1);

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge) begin
                    state_d          = S_RUNNING1;
                    lives_d          = LIVES_X;
                    inv_d            = '0;
                    pos_d            = '0;
                    phase_d          = PH_UP;
                    game_start_pulse = 1'b1;
                end
            end
            S_RUNNING1, S_RUNNING2: begin
                if (frame) begin
                    if (button_down) begin
                        state_d = S_DUCKING;
                    end else if (button_up) begin
                        state_d    = S_JUMPING;
                        phase_d    = PH_UP;
                        jump_pulse = 1'b1;
                    end else begin
                        state_d = (state_q == S_RUNNING1) ? S_RUNNING2 : S_RUNNING1;
                    end
                end
            end
            S_DUCKING: begin
                if (frame && !button_down)
                    state_d = S_RUNNING1;
            end
            S_JUMPING: begin
                if (phys) begin
                    if (phase_q == PH_UP) begin
                        if (pos_up >= HEIGHT_X) begin
                            pos_d   = HEIGHT_X[POS_W-1:0];
                            phase_d = PH_DOWN;
                        end else begin
                            pos_d = pos_up[POS_W-1:0];
                        end
                    end else if (pos_ext <= STEP_X) begin
                        pos_d   = '0;
                        state_d = S_RUNNING1;
                    end else begin
                        pos_d = pos_q - STEP_X[POS_W-1:0];
                    end
                end
            end
`ifdef PLAYER_PAUSE_EN
            S_PAUSED: begin
                if (start_edge)
                    state_d = saved_q;
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef PLAYER_PAUSE_EN
        // Pausing freezes the whole snapshot; a crash the same cycle beats the pause request.
        if (active && start_edge && !crash_ok) begin
            saved_d    = state_q;
            state_d    = S_PAUSED;
            pos_d      = pos_q;
            phase_d    = phase_q;
            jump_pulse = 1'b0;
        end
`endif

        if (hit) begin
            lives_d   = lives_q - LIVES_W'(1);
            inv_d     = INV_X;
            hit_pulse = 1'b1;
        end

        if (fatal) begin
            state_d         = S_GAME_OVER;
            lives_d         = '0;
            pos_d           = '0;
            phase_d         = PH_UP;
            jump_pulse      = 1'b0;
            game_over_pulse = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pos_q        <= '0;
            lives_q      <= '0;
            inv_q        <= '0;
            phase_q      <= PH_UP;
            start_prev_q <= 1'b0;
`ifdef PLAYER_PAUSE_EN
            saved_q      <= S_IDLE;
`endif
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            lives_q <= lives_d;
            inv_q   <= inv_d;
            phase_q <= phase_d;
            if (frame)
                start_prev_q <= button_start;
`ifdef PLAYER_PAUSE_EN
            saved_q <= saved_d;
`endif
        end
    end

    assign player_position = pos_q;
    assign lives_left      = lives_q;
    assign game_state      = state_q;
    assign invulnerable    = (inv_q != '0);

endmodule

// File: tb/tb_player_controller_gen2.sv
// tb/tb_player_controller_gen2.sv - directed self-checking bench for player_controller_gen2
module tb_player_controller_gen2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] game_tick;
    logic       button_up, button_down, button_start, crash;
    logic [5:0] player_position;
    logic [1:0] lives_left;
    logic [2:0] game_state;
    logic       invulnerable, game_start_pulse, jump_pulse, hit_pulse, game_over_pulse;

    int checks = 0;
    int errors = 0;

    player_controller_gen2 dut (
        .clk              (clk),
        .rst              (rst),
        .game_tick        (game_tick),
        .button_up        (button_up),
        .button_down      (button_down),
        .button_start     (button_start),
        .crash            (crash),
        .player_position  (player_position),
        .lives_left       (lives_left),
        .game_state       (game_state),
        .invulnerable     (invulnerable),
        .game_start_pulse (game_start_pulse),
        .jump_pulse       (jump_pulse),
        .hit_pulse        (hit_pulse),
        .game_over_pulse  (game_over_pulse)
    );

    always #5 clk = ~clk;

    // Advance one clock; strobes are cleared, button levels are kept.
    task automatic next();
        @(posedge clk);
        #1;
        game_tick = 2'b00;
        crash     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; game_tick = 2'b00; button_up = 1'b0; button_down = 1'b0;
        button_start = 1'b0; crash = 1'b0;
        next(); next();
        rst = 1'b0;
        #1;
        checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", game_state); end
        checks++; if (player_position !== 6'd0) begin errors++; $display("FAIL reset_pos got %0d exp 0", player_position); end
        checks++; if (lives_left !== 2'd0) begin errors++; $display("FAIL reset_lives got %0d exp 0", lives_left); end
        checks++; if ({invulnerable, game_start_pulse, jump_pulse, hit_pulse, game_over_pulse} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000",
                {invulnerable, game_start_pulse, jump_pulse, hit_pulse, game_over_pulse}); end
    endtask

    task automatic test_start();
        logic [2:0] exp_state;
        button_start = 1'b1; game_tick = 2'b01;
        #1;
        checks++; if (game_start_pulse !== 1'b1) begin errors++; $display("FAIL start_pulse got %b exp 1", game_start_pulse); end
        next();
        checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL start_state got %0d exp 2", game_state); end
        checks++; if (lives_left !== 2'd3) begin errors++; $display("FAIL start_lives got %0d exp 3", lives_left); end
        exp_state = 3'd2;
        for (int i = 0; i < 5; i++) begin
            game_tick = 2'b01;
            #1;
            checks++; if (game_start_pulse !== 1'b0) begin errors++; $display("FAIL held_start_pulse[%0d] got %b exp 0", i, game_start_pulse); end
            next();
            exp_state = (exp_state == 3'd2) ? 3'd3 : 3'd2;
            checks++; if (game_state !== exp_state) begin errors++; $display("FAIL held_start_state[%0d] got %0d exp %0d", i, game_state, exp_state); end
        end
        // Release on a frame tick so later edges are seen; state 3 -> 2
        button_start = 1'b0; game_tick = 2'b01;
        next();
        checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL release_state got %0d exp 2", game_state); end
    endtask

    task automatic test_jump();
        int exp_pos [12] = '{4, 8, 12, 16, 20, 24, 20, 16, 12, 8, 4, 0};
        button_up = 1'b1; game_tick = 2'b11;
        #1;
        checks++; if (jump_pulse !== 1'b1) begin errors++; $display("FAIL jump_pulse got %b exp 1", jump_pulse); end
        next();
        button_up = 1'b0;
        checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL jump_state got %0d exp 1", game_state); end
        checks++; if (player_position !== 6'd0) begin errors++; $display("FAIL jump_first_pos got %0d exp 0", player_position); end
        for (int i = 0; i < 12; i++) begin
            game_tick = 2'b10;
            next();
            checks++; if (player_position !== 6'(exp_pos[i])) begin
                errors++; $display("FAIL jump_pos[%0d] got %0d exp %0d", i, player_position, exp_pos[i]); end
        end
        checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL jump_land_state got %0d exp 2", game_state); end
    endtask

    task automatic test_duck();
        button_down = 1'b1; game_tick = 2'b01;
        next();
        checks++; if (game_state !== 3'd4) begin errors++; $display("FAIL duck_state got %0d exp 4", game_state); end
        game_tick = 2'b01;
        next();
        checks++; if (game_state !== 3'd4) begin errors++; $display("FAIL duck_hold got %0d exp 4", game_state); end
        button_down = 1'b0;
        next();
        checks++; if (game_state !== 3'd4) begin errors++; $display("FAIL duck_no_tick got %0d exp 4", game_state); end
        game_tick = 2'b01;
        next();
        checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL duck_release got %0d exp 2", game_state); end
    endtask

    task automatic test_hits();
        crash = 1'b1;
        #1;
        checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL hit1_pulse got %b exp 1", hit_pulse); end
        next();
        checks++; if (lives_left !== 2'd2) begin errors++; $display("FAIL hit1_lives got %0d exp 2", lives_left); end
        checks++; if (invulnerable !== 1'b1) begin errors++; $display("FAIL hit1_invuln got %b exp 1", invulnerable); end
        crash = 1'b1;
        #1;
        checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL invuln_crash_pulse got %b exp 0", hit_pulse); end
        next();
        for (int i = 0; i < 15; i++) begin game_tick = 2'b01; next(); end
        checks++; if (invulnerable !== 1'b1) begin errors++; $display("FAIL invuln_last_tick got %b exp 1", invulnerable); end
        // Counter reaches 0 in this cycle: the crash is still masked
        game_tick = 2'b01; crash = 1'b1;
        #1;
        checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL invuln_edge_pulse got %b exp 0", hit_pulse); end
        next();
        checks++; if (invulnerable !== 1'b0 || lives_left !== 2'd2) begin
            errors++; $display("FAIL invuln_expired got inv=%b lives=%0d exp inv=0 lives=2", invulnerable, lives_left); end
        crash = 1'b1;
        #1;
        checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL hit2_pulse got %b exp 1", hit_pulse); end
        next();
        checks++; if (lives_left !== 2'd1) begin errors++; $display("FAIL hit2_lives got %0d exp 1", lives_left); end
        for (int i = 0; i < 16; i++) begin game_tick = 2'b01; next(); end
        checks++; if (invulnerable !== 1'b0) begin errors++; $display("FAIL drain2 got %b exp 0", invulnerable); end
        // Fatal crash outranks the duck transition in the same cycle
        button_down = 1'b1; game_tick = 2'b01; crash = 1'b1;
        #1;
        checks++; if (game_over_pulse !== 1'b1 || hit_pulse !== 1'b0) begin
            errors++; $display("FAIL fatal_pulses got go=%b hit=%b exp go=1 hit=0", game_over_pulse, hit_pulse); end
        next();
        button_down = 1'b0;
        checks++; if (game_state !== 3'd5) begin errors++; $display("FAIL fatal_state got %0d exp 5", game_state); end
        checks++; if (lives_left !== 2'd0) begin errors++; $display("FAIL fatal_lives got %0d exp 0", lives_left); end
        crash = 1'b1;
        #1;
        checks++; if ({hit_pulse, game_over_pulse} !== 2'b00) begin
            errors++; $display("FAIL over_crash got %b exp 00", {hit_pulse, game_over_pulse}); end
        next();
    endtask

    task automatic test_restart();
        button_start = 1'b1; game_tick = 2'b01;
        #1;
        checks++; if (game_start_pulse !== 1'b1) begin errors++; $display("FAIL restart_pulse got %b exp 1", game_start_pulse); end
        next();
        checks++; if (game_state !== 3'd2 || lives_left !== 2'd3 || invulnerable !== 1'b0) begin
            errors++; $display("FAIL restart got state=%0d lives=%0d inv=%b exp 2 3 0", game_state, lives_left, invulnerable); end
        button_start = 1'b0; game_tick = 2'b01;
        next();
    endtask

`ifdef PLAYER_PAUSE_EN
    task automatic test_pause();
        button_up = 1'b1; game_tick = 2'b01;
        next();
        button_up = 1'b0;
        for (int i = 0; i < 3; i++) begin game_tick = 2'b10; next(); end
        checks++; if (player_position !== 6'd12) begin errors++; $display("FAIL pre_pause_pos got %0d exp 12", player_position); end
        button_start = 1'b1; game_tick = 2'b01;
        next();
        checks++; if (game_state !== 3'd6) begin errors++; $display("FAIL pause_state got %0d exp 6", game_state); end
        game_tick = 2'b11; crash = 1'b1;
        #1;
        checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL pause_crash got %b exp 0", hit_pulse); end
        next();
        button_start = 1'b0; game_tick = 2'b01;
        next();
        checks++; if (game_state !== 3'd6 || player_position !== 6'd12 || lives_left !== 2'd3) begin
            errors++; $display("FAIL paused_hold got state=%0d pos=%0d lives=%0d exp 6 12 3", game_state, player_position, lives_left); end
        button_start = 1'b1; game_tick = 2'b01;
        next();
        button_start = 1'b0;
        checks++; if (game_state !== 3'd1 || player_position !== 6'd12) begin
            errors++; $display("FAIL resume got state=%0d pos=%0d exp 1 12", game_state, player_position); end
        game_tick = 2'b10;
        next();
        checks++; if (player_position !== 6'd16) begin errors++; $display("FAIL resume_step got %0d exp 16", player_position); end
    endtask
`endif

    task automatic test_reset_mid_jump();
        button_up = 1'b1; game_tick = 2'b01;
        next();
        button_up = 1'b0;
        game_tick = 2'b10;
        next();
        rst = 1'b1; game_tick = 2'b11; crash = 1'b1;
        next();
        rst = 1'b0;
        checks++; if (game_state !== 3'd0 || player_position !== 6'd0 || lives_left !== 2'd0) begin
            errors++; $display("FAIL reset_mid_jump got state=%0d pos=%0d lives=%0d exp 0 0 0", game_state, player_position, lives_left); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_jump();
        test_duck();
        test_hits();
        test_restart();
`ifdef PLAYER_PAUSE_EN
        test_pause();
`endif
        test_reset_mid_jump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
